// File: rtl/approx_eval_pkg.sv
// Shared state encoding and width helpers for the approximate-adder error sweep.
// Widths are functions of the operand width so every module derives identical sizes.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    // Exact sum and |diff| width.
    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    // Signed difference dut_sum - exact.
    function automatic int diff_w(input int w);
        return w + 2;
    endfunction

    // Full-width square of |diff|.
    function automatic int sq_w(input int w);
        return 2 * w + 2;
    endfunction

    // Mismatch counter: up to 2^(2w) pairs.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // Sum of |diff| over all pairs, sized so it cannot wrap.
    function automatic int abs_acc_w(input int w);
        return 3 * w + 2;
    endfunction

    // Sum of diff^2 over all pairs, sized so it cannot wrap.
    function automatic int sq_acc_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Error metric datapath: diff, |diff| and diff^2 of one captured pair,
// plus the mismatch count, |diff| sum, diff^2 sum and running max.
module approx_err_accum
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             cap_a_i,
    input  logic [WIDTH-1:0]             cap_b_i,
    input  logic [WIDTH:0]               cap_sum_i,
    input  logic                         clear_i,
    input  logic                         en_i,
    output logic [cnt_w(WIDTH)-1:0]      err_cnt_o,
    output logic [abs_acc_w(WIDTH)-1:0]  abs_sum_o,
    output logic [sq_acc_w(WIDTH)-1:0]   sq_sum_o,
    output logic [sum_w(WIDTH)-1:0]      max_abs_o
);

    localparam int SUM_W     = sum_w(WIDTH);
    localparam int DIFF_W    = diff_w(WIDTH);
    localparam int SQ_W      = sq_w(WIDTH);
    localparam int CNT_W     = cnt_w(WIDTH);
    localparam int ABS_ACC_W = abs_acc_w(WIDTH);
    localparam int SQ_ACC_W  = sq_acc_w(WIDTH);

    logic [SUM_W-1:0]         exact;
    logic signed [DIFF_W-1:0] diff;
    logic signed [DIFF_W-1:0] neg_diff;
    logic [SUM_W-1:0]         abs_diff;
    logic [SQ_W-1:0]          sq;

    logic [CNT_W-1:0]     err_q, err_d;
    logic [ABS_ACC_W-1:0] abs_q, abs_d;
    logic [SQ_ACC_W-1:0]  sqs_q, sqs_d;
    logic [SUM_W-1:0]     max_q, max_d;

    always_comb begin
        exact    = SUM_W'(cap_a_i) + SUM_W'(cap_b_i);
        diff     = $signed({1'b0, cap_sum_i}) - $signed({1'b0, exact});
        neg_diff = -diff;
        // |diff| never exceeds 2^(WIDTH+1)-1, so the top bit can be dropped.
        abs_diff = diff[DIFF_W-1] ? neg_diff[SUM_W-1:0] : diff[SUM_W-1:0];
        sq       = SQ_W'(abs_diff) * SQ_W'(abs_diff);
    end

    always_comb begin
        err_d = err_q;
        abs_d = abs_q;
        sqs_d = sqs_q;
        max_d = max_q;
        if (clear_i) begin
            err_d = '0;
            abs_d = '0;
            sqs_d = '0;
            max_d = '0;
        end else if (en_i) begin
            err_d = err_q + CNT_W'(diff != '0);
            abs_d = abs_q + ABS_ACC_W'(abs_diff);
            sqs_d = sqs_q + SQ_ACC_W'(sq);
            if (abs_diff > max_q) begin
                max_d = abs_diff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
            abs_q <= '0;
            sqs_q <= '0;
            max_q <= '0;
        end else begin
            err_q <= err_d;
            abs_q <= abs_d;
            sqs_q <= sqs_d;
            max_q <= max_d;
        end
    end

    assign err_cnt_o = err_q;
    assign abs_sum_o = abs_q;
    assign sq_sum_o  = sqs_q;
    assign max_abs_o = max_q;

endmodule

// File: rtl/approx_add_sweep_ctrl.sv
// Exhaustive operand sweep sequencer for an external approximate adder.
// Issues every (op_a, op_b) pair, captures the adder output, and accumulates error metrics.
module approx_add_sweep_ctrl
    import approx_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         res_valid,
    output logic [WIDTH-1:0]             op_a,
    output logic [WIDTH-1:0]             op_b,
    input  logic [WIDTH:0]               dut_sum,
    output logic [cnt_w(WIDTH)-1:0]      err_cnt,
    output logic [abs_acc_w(WIDTH)-1:0]  abs_sum,
    output logic [sq_acc_w(WIDTH)-1:0]   sq_sum,
    output logic [sum_w(WIDTH)-1:0]      max_abs
);

    sweep_state_e state_q, state_d;

    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [WIDTH:0]   cap_sum_q, cap_sum_d;
    logic             cap_vld_q, cap_vld_d;
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic             clear_acc;
    logic             last_pair;

    assign last_pair = (&op_a_q) && (&op_b_q);

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        cap_sum_d   = cap_sum_q;
        cap_vld_d   = 1'b0;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        clear_acc   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end else if (start) begin
                    state_d     = ST_SWEEP;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    res_valid_d = 1'b0;
                    clear_acc   = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    res_valid_d = 1'b0;
                end else begin
                    // dut_sum is only sampled here, while the operands are defined.
                    cap_a_d   = op_a_q;
                    cap_b_d   = op_b_q;
                    cap_sum_d = dut_sum;
                    cap_vld_d = 1'b1;
                    if (last_pair) begin
                        state_d = ST_DRAIN;
                        op_a_d  = '0;
                        op_b_d  = '0;
                    end else begin
                        op_b_d = op_b_q + 1'b1;
                        if (&op_b_q) begin
                            op_a_d = op_a_q + 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_sum_q   <= '0;
            cap_vld_q   <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            cap_sum_q   <= cap_sum_d;
            cap_vld_q   <= cap_vld_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
        end
    end

    approx_err_accum #(
        .WIDTH(WIDTH)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .cap_a_i   (cap_a_q),
        .cap_b_i   (cap_b_q),
        .cap_sum_i (cap_sum_q),
        .clear_i   (clear_acc),
        .en_i      (cap_vld_q),
        .err_cnt_o (err_cnt),
        .abs_sum_o (abs_sum),
        .sq_sum_o  (sq_sum),
        .max_abs_o (max_abs)
    );

    assign busy      = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

endmodule

// File: tb/tb_approx_add_sweep_ctrl.sv
// Directed bench: four WIDTH=8 sweeps in parallel against different stub adders,
// plus a WIDTH=2 instance for abort, reset and start-while-busy behaviour.
module tb_approx_add_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // WIDTH=8 instances: 0 exact, 1 exact+1, 2 constant zero, 3 low-nibble OR adder
    logic        rst8, start8, abort8;
    logic        busy8 [4];
    logic        done8 [4];
    logic        rv8   [4];
    logic [7:0]  a8    [4];
    logic [7:0]  b8    [4];
    logic [8:0]  s8    [4];
    logic [16:0] err8  [4];
    logic [25:0] abs8  [4];
    logic [33:0] sq8   [4];
    logic [8:0]  max8  [4];

    for (genvar g = 0; g < 4; g++) begin : g_w8
        approx_add_sweep_ctrl #(.WIDTH(8)) dut (
            .clk(clk), .rst(rst8), .start(start8), .abort(abort8),
            .busy(busy8[g]), .done(done8[g]), .res_valid(rv8[g]),
            .op_a(a8[g]), .op_b(b8[g]), .dut_sum(s8[g]),
            .err_cnt(err8[g]), .abs_sum(abs8[g]), .sq_sum(sq8[g]), .max_abs(max8[g])
        );
        if (g == 0) begin : g_exact
            assign s8[g] = {1'b0, a8[g]} + {1'b0, b8[g]};
        end else if (g == 1) begin : g_plus1
            assign s8[g] = {1'b0, a8[g]} + {1'b0, b8[g]} + 9'd1;
        end else if (g == 2) begin : g_zero
            assign s8[g] = '0;
        end else begin : g_loa
            assign s8[g] = {({1'b0, a8[g][7:4]} + {1'b0, b8[g][7:4]}), (a8[g][3:0] | b8[g][3:0])};
        end
    end

    // WIDTH=2 instance with a constant-zero adder
    logic       rst2, start2, abort2, busy2, done2, rv2;
    logic [1:0] a2, b2;
    logic [2:0] s2;
    logic [4:0] err2;
    logic [7:0] abs2;
    logic [9:0] sq2;
    logic [2:0] max2;
    assign s2 = '0;

    approx_add_sweep_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .res_valid(rv2),
        .op_a(a2), .op_b(b2), .dut_sum(s2),
        .err_cnt(err2), .abs_sum(abs2), .sq_sum(sq2), .max_abs(max2)
    );

    function automatic int loa_ref(input int a, input int b);
        return ((a / 16) + (b / 16)) * 16 + ((a % 16) | (b % 16));
    endfunction

    // Full WIDTH=2 sweep with start pulses while busy; done must rise 17 edges after start.
    task automatic sweep2(input string tag);
        int done_at = -1;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(negedge clk);
            start2 = (k == 3) || (k == 9);
            if (done2 && done_at < 0) done_at = k;
            if (k == 17) chk({tag, " rv at done"}, rv2, 1);
            if (k == 18) chk({tag, " done fall"}, done2, 0);
        end
        start2 = 1'b0;
        chk({tag, " done edge"}, done_at, 17);
        chk({tag, " err_cnt"}, err2, 15);
        chk({tag, " abs_sum"}, abs2, 48);
        chk({tag, " sq_sum"}, sq2, 184);
        chk({tag, " max_abs"}, max2, 6);
        chk({tag, " busy"}, busy2, 0);
    endtask

    initial begin
        int cnt;
        int order_err;
        int done_at8 [4];
        longint g_err, g_abs, g_sq, g_max;

        rst8 = 1'b1; rst2 = 1'b1;
        start8 = 1'b0; start2 = 1'b0; abort8 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        chk("rst w2 busy", busy2, 0);
        chk("rst w2 res_valid", rv2, 0);
        chk("rst w2 err_cnt", err2, 0);
        chk("rst w8 busy", busy8[3], 0);
        chk("rst w8 op_a", a8[3], 0);
        chk("rst w8 sq_sum", sq8[2], 0);

        // Abort on the 7th SWEEP cycle
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        repeat (6) @(negedge clk);
        chk("w2 pair6 op_a", a2, 1);
        chk("w2 pair6 op_b", b2, 2);
        abort2 = 1'b1;
        @(negedge clk) abort2 = 1'b0;
        chk("w2 abort busy", busy2, 0);
        chk("w2 abort op_a", a2, 0);
        chk("w2 abort op_b", b2, 0);
        chk("w2 abort res_valid", rv2, 0);
        chk("w2 abort done", done2, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done2 || busy2) cnt++;
        end
        chk("w2 idle after abort", cnt, 0);

        sweep2("w2 sweep1");

        // DONE holds results
        repeat (4) @(negedge clk);
        chk("w2 hold res_valid", rv2, 1);
        chk("w2 hold done", done2, 0);
        chk("w2 hold err_cnt", err2, 15);

        // start and abort together in DONE: abort wins
        start2 = 1'b1; abort2 = 1'b1;
        @(negedge clk) begin start2 = 1'b0; abort2 = 1'b0; end
        chk("w2 start+abort busy", busy2, 0);
        chk("w2 start+abort res_valid", rv2, 0);
        chk("w2 start+abort err_cnt", err2, 15);

        // Asynchronous reset mid-sweep
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("w2 pre-rst op_b", b2, 1);
        chk("w2 pre-rst err_cnt", err2, 3);
        #2 rst2 = 1'b1;
        #1;
        chk("w2 rst busy", busy2, 0);
        chk("w2 rst op_a", a2, 0);
        chk("w2 rst op_b", b2, 0);
        chk("w2 rst err_cnt", err2, 0);
        chk("w2 rst abs_sum", abs2, 0);
        chk("w2 rst sq_sum", sq2, 0);
        chk("w2 rst max_abs", max2, 0);
        @(negedge clk) rst2 = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done2 || busy2 || rv2) cnt++;
        end
        chk("w2 idle after rst", cnt, 0);

        sweep2("w2 sweep2");

        // WIDTH=8 full sweep, all four stubs in parallel
        order_err = 0;
        g_err = 0; g_abs = 0; g_sq = 0; g_max = 0;
        for (int i = 0; i < 4; i++) done_at8[i] = -1;
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        for (int k = 0; k <= 65538; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 65536) begin
                int ea, eb, d, ad;
                ea = k / 256;
                eb = k % 256;
                if (a8[3] !== 8'(ea) || b8[3] !== 8'(eb)) order_err++;
                d  = loa_ref(ea, eb) - (ea + eb);
                ad = (d < 0) ? -d : d;
                if (ad != 0) g_err++;
                g_abs += ad;
                g_sq  += longint'(ad) * longint'(ad);
                if (ad > g_max) g_max = ad;
            end else if (k == 65536) begin
                chk("w8 drain op_a", a8[3], 0);
                chk("w8 drain op_b", b8[3], 0);
                chk("w8 drain busy", busy8[3], 1);
            end
            for (int i = 0; i < 4; i++)
                if (done8[i] && done_at8[i] < 0) done_at8[i] = k;
            if (k == 65538) chk("w8 done fall", done8[0], 0);
        end
        chk("w8 pair order", order_err, 0);
        chk("w8 exact done edge", done_at8[0], 65537);
        chk("w8 loa done edge", done_at8[3], 65537);

        chk("w8 exact err_cnt", err8[0], 0);
        chk("w8 exact abs_sum", abs8[0], 0);
        chk("w8 exact sq_sum", sq8[0], 0);
        chk("w8 exact max_abs", max8[0], 0);
        chk("w8 exact res_valid", rv8[0], 1);

        chk("w8 plus1 err_cnt", err8[1], 65536);
        chk("w8 plus1 abs_sum", abs8[1], 65536);
        chk("w8 plus1 sq_sum", sq8[1], 65536);
        chk("w8 plus1 max_abs", max8[1], 1);

        chk("w8 zero err_cnt", err8[2], 65535);
        chk("w8 zero abs_sum", abs8[2], 16711680);
        chk("w8 zero sq_sum", sq8[2], 64'd4977295360);
        chk("w8 zero max_abs", max8[2], 510);

        chk("w8 loa err_cnt", err8[3], g_err);
        chk("w8 loa abs_sum", abs8[3], g_abs);
        chk("w8 loa sq_sum", sq8[3], g_sq);
        chk("w8 loa max_abs", max8[3], g_max);
        chk("w8 loa busy", busy8[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
